imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Parametrised, registered immediate-generation stage for the decode pipeline.
- Takes a fetched instruction and PC over a valid/ready handshake.
- Decodes the full RV32I/RV64I immediate set (I, S, B, U, J) sign-extended to XLEN, and reports the format and an illegal-opcode flag.
- Contains a two-entry skid buffer so upstream fetch and downstream execute can stall independently without losing or duplicating instructions.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64. Any other value is an elaboration error.
- EN_RV64, 0, when 1 and XLEN=64, opcode 0011011 (OP-IMM-32) decodes as I-type; otherwise that opcode is illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts this cycle
- out_inst  out  32  instruction passed through
- out_pc  out  XLEN  PC passed through
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
- out_illegal  out  1  opcode not recognised

Behaviour:
- Decode (combinational on in_inst, captured at accept time):
  - I-type opcodes: 0000011, 0010011, 1100111, 1110011, and 0011011 when EN_RV64. Immediate is sext(inst[31:20]).
  - Shift-immediates are not special-cased: SRAI yields 0x400|shamt.
  - S-type, opcode 0100011: sext({inst[31:25], inst[11:7]}).
  - B-type, opcode 1100011: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U-type, opcodes 0110111 and 0010111: sext({inst[31:12], 12'b0}). With XLEN=64, bit 31 extends into the upper half.
  - J-type, opcode 1101111: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R-type 0110011, plus 0111011 when EN_RV64, and FENCE 0001111: fmt NONE, imm 0, legal.
  - Any other opcode, or inst[1:0] != 2'b11: fmt NONE, imm 0, out_illegal=1.
- Buffering: main register M drives all out_* signals; skid register K is a second entry.
  - in_ready = !K.valid. It is a registered value, with no combinational path from out_ready.
  - Accept: in_valid && in_ready.
  - Emit: out_valid && out_ready.
  - M empty, or M emitting this cycle: M loads from K if K is valid, else from the input on accept. K loads only when an accept occurs while M holds and is not emitting.
  - Accept while K is full cannot occur, because in_ready=0.
  - Simultaneous accept and emit with K empty: M takes the new entry and throughput is 1 per cycle.
  - Simultaneous accept and emit with K full: in_ready=0, so M takes K and K becomes empty.
  - Order is strictly preserved.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- flush:
  - On the next edge, M.valid=0 and K.valid=0.
  - Any input presented that cycle is dropped, even if in_ready=1. Flush dominates accept and emit.
  - in_ready=1 in the following cycle.
- Reset:
  - Asynchronous assertion at any time, including mid-stall: out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_inst=0, out_pc=0, K cleared.
  - Deassertion is synchronised externally.
- Stability: while out_valid=1 and out_ready=0, all out_* signals hold their values.

Test Plan:
- XLEN=32, inject 0xFF1FF06F (jal x0,-16) -> next cycle out_valid=1, out_fmt=5, out_imm=0xFFFFFFF0.
- XLEN=32, back-to-back 0xFFC12083 (lw), 0x00512423 (sw), 0xFE000EE3 (beq) with out_ready=1 -> outputs on consecutive cycles:
  - lw: fmt 1, imm 0xFFFFFFFC
  - sw: fmt 2, imm 0x00000008
  - beq: fmt 3, imm 0xFFFFFFFC
- XLEN=64, inject 0x123450B7 then 0x800000B7 -> out_imm 0x0000000012345000, then 0xFFFFFFFF80000000, both fmt 4. Separately, 0x0000007F -> out_illegal=1, imm 0.
- Back-pressure: out_ready=0 for 4 cycles while 3 instructions are offered:
  - first goes to M, second to K, in_ready=0 at cycle 2, third held upstream.
  - release out_ready: all 3 emerge in order, none duplicated or lost.
- Flush with M and K both full and in_valid=1 -> next cycle out_valid=0, in_ready=1. The dropped input does not appear later.
- Assert rst_n=0 mid-stall with K full -> all outputs 0 immediately, in_ready=1. After release, a new instruction has 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate-generation stage with a two-entry skid buffer.
// M drives every output; K absorbs one extra accept while M is stalled, so
// in_ready can come straight from a flop with no path from out_ready.
module imm_gen_stage #(
  parameter int XLEN    = 32,
  parameter int EN_RV64 = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
    end
  endgenerate

  // The 32-bit-word ops only exist on a 64-bit datapath.
  localparam bit RV64_OPS = (EN_RV64 != 0) && (XLEN == 64);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  // Candidate immediates; signed size casts perform the sign extension.
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                in_inst[30:21], 1'b0}));

  entry_t dec;

  // Opcode decode; every listed opcode ends in 2'b11, so compressed or
  // malformed encodings fall through to the illegal default.
  always_comb begin
    dec.inst    = in_inst;
    dec.pc      = in_pc;
    dec.imm     = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (in_inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        dec.fmt = FMT_I;
        dec.imm = imm_i;
      end
      OP_IMM32: begin
        if (RV64_OPS) begin
          dec.fmt = FMT_I;
          dec.imm = imm_i;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = imm_s;
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = imm_b;
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = imm_u;
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = imm_j;
      end
      OP_OP, OP_FENCE: begin
        dec.fmt = FMT_NONE;
      end
      OP_OP32: begin
        dec.illegal = !RV64_OPS;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  entry_t m_q;
  entry_t k_q;
  logic   m_valid;
  logic   k_valid;
  logic   accept;
  logic   emit;
  logic   m_free;

  assign in_ready = !k_valid;
  assign accept   = in_valid && in_ready;
  assign emit     = m_valid && out_ready;
  assign m_free   = !m_valid || emit;

  // Buffer update: M refills from K first to keep order; K only catches an
  // accept that arrives while M is stalled. Flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (m_free) begin
      if (k_valid) begin
        m_q     <= k_q;
        m_valid <= 1'b1;
        k_valid <= 1'b0;
      end else if (accept) begin
        m_q     <= dec;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      k_q     <= dec;
      k_valid <= 1'b1;
    end
  end

  assign out_valid   = m_valid;
  assign out_inst    = m_q.inst;
  assign out_pc      = m_q.pc;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: one XLEN=32 and one XLEN=64/EN_RV64 instance run in
// lockstep against a queue-based reference model plus directed scenarios.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        r32_in_ready, r32_out_valid, r32_out_illegal;
  logic [31:0] r32_out_inst, r32_out_pc, r32_out_imm;
  logic [2:0]  r32_out_fmt;

  logic        r64_in_ready, r64_out_valid, r64_out_illegal;
  logic [31:0] r64_out_inst;
  logic [63:0] r64_out_pc, r64_out_imm;
  logic [2:0]  r64_out_fmt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .EN_RV64(0)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(r32_out_valid), .out_ready(out_ready),
    .out_inst(r32_out_inst), .out_pc(r32_out_pc), .out_imm(r32_out_imm),
    .out_fmt(r32_out_fmt), .out_illegal(r32_out_illegal)
  );

  imm_gen_stage #(.XLEN(64), .EN_RV64(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(r64_out_valid), .out_ready(out_ready),
    .out_inst(r64_out_inst), .out_pc(r64_out_pc), .out_imm(r64_out_imm),
    .out_fmt(r64_out_fmt), .out_illegal(r64_out_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } txn_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ref_t;

  txn_t        mq[$];
  logic [31:0] emitted[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sx(longint val, int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (val >= half) ? val - (half * 2) : val;
  endfunction

  // Architectural immediate rules evaluated with plain arithmetic.
  function automatic ref_t ref_decode(logic [31:0] inst, bit is64);
    ref_t   r;
    longint v;
    v     = 0;
    r.fmt = 3'd0;
    r.ill = 1'b0;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        r.fmt = 3'd1;
        v = sx(longint'(inst[31:20]), 12);
      end
      7'h1B: begin
        if (is64) begin
          r.fmt = 3'd1;
          v = sx(longint'(inst[31:20]), 12);
        end else r.ill = 1'b1;
      end
      7'h23: begin
        r.fmt = 3'd2;
        v = sx(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
      end
      7'h63: begin
        r.fmt = 3'd3;
        v = sx(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
               longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin
        r.fmt = 3'd4;
        v = sx(longint'(inst[31:12]) * 4096, 32);
      end
      7'h6F: begin
        r.fmt = 3'd5;
        v = sx(longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096 +
               longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
      end
      7'h33, 7'h0F: r.fmt = 3'd0;
      7'h3B: r.ill = !is64;
      default: r.ill = 1'b1;
    endcase
    if (is64) r.imm = v;
    else      r.imm = v & 64'hFFFF_FFFF;
    return r;
  endfunction

  task automatic compare_model();
    ref_t r;
    bit   ev;
    ev = (mq.size() > 0);
    check("valid32", r32_out_valid, ev);
    check("valid64", r64_out_valid, ev);
    check("ready32", r32_in_ready, mq.size() < 2);
    check("ready64", r64_in_ready, mq.size() < 2);
    if (ev) begin
      r = ref_decode(mq[0].inst, 1'b0);
      check("inst32", r32_out_inst, mq[0].inst);
      check("pc32",   r32_out_pc,   {32'b0, mq[0].pc[31:0]});
      check("imm32",  r32_out_imm,  r.imm);
      check("fmt32",  r32_out_fmt,  r.fmt);
      check("ill32",  r32_out_illegal, r.ill);
      r = ref_decode(mq[0].inst, 1'b1);
      check("inst64", r64_out_inst, mq[0].inst);
      check("pc64",   r64_out_pc,   mq[0].pc);
      check("imm64",  r64_out_imm,  r.imm);
      check("fmt64",  r64_out_fmt,  r.fmt);
      check("ill64",  r64_out_illegal, r.ill);
    end
    if (r32_out_valid && out_ready) emitted.push_back(r32_out_inst);
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    bit acc;
    @(negedge clk);
    compare_model();
    @(posedge clk);
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) mq.push_back('{in_inst, in_pc});
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_v32"},   r32_out_valid, 1'b0);
    check({tag, "_rdy32"}, r32_in_ready, 1'b1);
    check({tag, "_imm32"}, r32_out_imm, 64'd0);
    check({tag, "_fmt32"}, r32_out_fmt, 64'd0);
    check({tag, "_ill32"}, r32_out_illegal, 64'd0);
    check({tag, "_ins32"}, r32_out_inst, 64'd0);
    check({tag, "_pc32"},  r32_out_pc, 64'd0);
    check({tag, "_v64"},   r64_out_valid, 1'b0);
    check({tag, "_rdy64"}, r64_in_ready, 1'b1);
    check({tag, "_imm64"}, r64_out_imm, 64'd0);
    check({tag, "_fmt64"}, r64_out_fmt, 64'd0);
    check({tag, "_ill64"}, r64_out_illegal, 64'd0);
    check({tag, "_ins64"}, r64_out_inst, 64'd0);
    check({tag, "_pc64"},  r64_out_pc, 64'd0);
  endtask

  logic [6:0]  ops[13] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h3B};
  logic [31:0] bb_inst[3] = '{32'hFFC12083, 32'h00512423, 32'hFE000EE3};
  logic [2:0]  bb_fmt[3]  = '{3'd1, 3'd2, 3'd3};
  logic [31:0] bb_imm[3]  = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC};
  logic [31:0] u_inst[3]  = '{32'h123450B7, 32'h800000B7, 32'h0000007F};
  logic [63:0] u_imm[3]   = '{64'h0000000012345000, 64'hFFFFFFFF80000000, 64'd0};
  logic [2:0]  u_fmt[3]   = '{3'd4, 3'd4, 3'd0};
  logic        u_ill[3]   = '{1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ri;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    #2;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single jal into an empty stage: one-cycle latency.
    in_valid = 1'b1; in_inst = 32'hFF1FF06F; in_pc = 64'h1000; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("jal_valid", r32_out_valid, 1'b1);
    check("jal_fmt",   r32_out_fmt, 3'd5);
    check("jal_imm",   r32_out_imm, 32'hFFFFFFF0);
    cycle();

    // Back-to-back lw/sw/beq at full throughput.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = bb_inst[i]; in_pc = 64'h2000 + 64'(4 * i);
      cycle();
      check("bb_valid", r32_out_valid, 1'b1);
      check("bb_fmt",   r32_out_fmt, bb_fmt[i]);
      check("bb_imm",   r32_out_imm, bb_imm[i]);
    end
    in_valid = 1'b0;
    cycle();

    // 64-bit U-type sign extension and an illegal opcode.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = u_inst[i]; in_pc = 64'h8000_0000_0000_3000 + 64'(4 * i);
      cycle();
      check("u64_imm", r64_out_imm, u_imm[i]);
      check("u64_fmt", r64_out_fmt, u_fmt[i]);
      check("u64_ill", r64_out_illegal, u_ill[i]);
    end
    in_valid = 1'b0;
    cycle();

    // Back-pressure: three offered while the sink stalls for four cycles.
    emitted.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00100093; in_pc = 64'h4000;
    cycle();
    check("bp_rdy1", r32_in_ready, 1'b1);
    in_inst = 32'h00200113; in_pc = 64'h4004;
    cycle();
    check("bp_rdy2", r32_in_ready, 1'b0);
    in_inst = 32'h00300193; in_pc = 64'h4008;
    cycle();
    cycle();
    check("bp_hold", r32_out_inst, 32'h00100093);
    out_ready = 1'b1;
    cycle();
    check("bp_second", r32_out_inst, 32'h00200113);
    cycle();
    check("bp_third", r32_out_inst, 32'h00300193);
    in_valid = 1'b0;
    cycle();
    check("bp_count", 64'(emitted.size()), 64'd3);
    if (emitted.size() == 3) begin
      check("bp_ord0", emitted[0], 32'h00100093);
      check("bp_ord1", emitted[1], 32'h00200113);
      check("bp_ord2", emitted[2], 32'h00300193);
    end

    // Flush with both entries full and a pending input.
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00400213; in_pc = 64'h5000; cycle();
    in_inst = 32'h00500293; in_pc = 64'h5004; cycle();
    in_inst = 32'h00600313; in_pc = 64'h5008; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", r32_out_valid, 1'b0);
    check("fl_ready", r32_in_ready, 1'b1);
    out_ready = 1'b1;
    emitted.delete();
    repeat (3) cycle();
    check("fl_none", 64'(emitted.size()), 64'd0);

    // Flush drops an input even when in_ready is high.
    in_valid = 1'b1; in_inst = 32'h00700393; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_drop", r32_out_valid, 1'b0);

    // Asynchronous reset in the middle of a stall with K full.
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00800413; in_pc = 64'h6000; cycle();
    in_inst = 32'h00900493; in_pc = 64'h6004; cycle();
    in_inst = 32'h00A00513; in_pc = 64'h6008;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    mq.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    check("rst_lat_v", r32_out_valid, 1'b1);
    check("rst_lat_i", r32_out_inst, 32'h00A00513);
    in_valid = 1'b0;
    cycle();

    // Randomised traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 9) < 8) ri[6:0] = ops[$urandom_range(0, 12)];
      in_inst   = ri;
      in_pc     = {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
